// File: rtl/dct_2d_ctrl.sv
// dct_2d_ctrl: sequences one shared 8-point 1D DCT engine through a row pass,
// an on-chip transpose and a column pass to produce a full 8x8 2D DCT block.
//
// Handshakes: a beat moves on a port only in a cycle where valid && ready are
// both high at the rising clock edge. A source holds valid and data until that
// happens. The sink side (out_valid/out_data) is held stable while out_ready=0.
module dct_2d_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ENGINE_LAT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH*8-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH*8-1:0] out_data,
    output logic [DATA_WIDTH*8-1:0] eng_data_in,
    input  logic [DATA_WIDTH*8-1:0] eng_data_out,
    output logic                    busy,
    output logic                    block_done
);

    localparam int VW = DATA_WIDTH * 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROW  = 2'd1;
    localparam logic [1:0] S_COL  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    row_cnt_q, row_cnt_d;   // rows accepted (0..8)
    logic [3:0]    col_cnt_q, col_cnt_d;   // columns issued (0..8)
    logic [2:0]    cap_cnt_q, cap_cnt_d;   // tagged results captured in current pass
    logic [2:0]    out_cnt_q, out_cnt_d;   // output row index
    logic          in_ready_q, in_ready_d;
    logic [VW-1:0] eng_q, eng_d;
    logic          issue_d;

    // Stage 0 travels with eng_data_in; the next ENGINE_LAT stages follow the
    // engine latency, so the top bit lines up with the matching engine output.
    logic [ENGINE_LAT:0] tag_q;
    logic                cap_fire;

    // Transpose buffer (row results) and output buffer (column results).
    logic [VW-1:0] tbuf_q [8];
    logic [VW-1:0] obuf_q [8];
    logic [VW-1:0] col_vec;
    logic          accept;

    assign accept   = in_valid && in_ready_q;
    assign cap_fire = tag_q[ENGINE_LAT];

    // Gather column col_cnt from the transpose buffer: lane r = tbuf[r][col].
    always_comb begin
        col_vec = '0;
        for (int r = 0; r < 8; r++) begin
            col_vec[r*DATA_WIDTH +: DATA_WIDTH] =
                tbuf_q[r][col_cnt_q[2:0]*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next-state, counter and engine-issue decisions.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        cap_cnt_d = cap_cnt_q;
        out_cnt_d = out_cnt_q;
        eng_d     = eng_q;
        issue_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_ROW;
                    eng_d     = in_data;
                    issue_d   = 1'b1;
                    row_cnt_d = 4'd1;
                    cap_cnt_d = 3'd0;
                end
            end
            S_ROW: begin
                // Acceptance and capture may coincide; both are handled.
                if (accept) begin
                    eng_d     = in_data;
                    issue_d   = 1'b1;
                    row_cnt_d = row_cnt_q + 4'd1;
                end
                if (cap_fire) begin
                    cap_cnt_d = cap_cnt_q + 3'd1;
                    if (cap_cnt_q == 3'd7) begin
                        state_d   = S_COL;
                        col_cnt_d = 4'd0;
                    end
                end
            end
            S_COL: begin
                if (col_cnt_q < 4'd8) begin
                    eng_d     = col_vec;
                    issue_d   = 1'b1;
                    col_cnt_d = col_cnt_q + 4'd1;
                end
                if (cap_fire) begin
                    cap_cnt_d = cap_cnt_q + 3'd1;
                    if (cap_cnt_q == 3'd7) begin
                        state_d   = S_OUT;
                        out_cnt_d = 3'd0;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        state_d   = S_IDLE;
                        row_cnt_d = 4'd0;
                        col_cnt_d = 4'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || ((state_d == S_ROW) && (row_cnt_d < 4'd8));
    end

    // Control state, counters, engine input register and tag pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_cnt_q  <= 4'd0;
            col_cnt_q  <= 4'd0;
            cap_cnt_q  <= 3'd0;
            out_cnt_q  <= 3'd0;
            in_ready_q <= 1'b0;
            eng_q      <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            out_cnt_q  <= out_cnt_d;
            in_ready_q <= in_ready_d;
            eng_q      <= eng_d;
            tag_q      <= {tag_q[ENGINE_LAT-1:0], issue_d};
        end
    end

    // Capture tagged engine results into the transpose or output buffer.
    always_ff @(posedge clk) begin
        if (cap_fire && (state_q == S_ROW)) begin
            tbuf_q[cap_cnt_q] <= eng_data_out;
        end
        if (cap_fire && (state_q == S_COL)) begin
            for (int v = 0; v < 8; v++) begin
                obuf_q[v][cap_cnt_q*DATA_WIDTH +: DATA_WIDTH] <=
                    eng_data_out[v*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign eng_data_in = eng_q;
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign out_data    = (state_q == S_OUT) ? obuf_q[out_cnt_q] : '0;
    assign block_done  = (state_q == S_OUT) && out_ready && (out_cnt_q == 3'd7);

endmodule

// File: tb/tb_dct_2d_ctrl.sv
// tb_dct_2d_ctrl: self-checking bench for dct_2d_ctrl with a behavioural
// engine model (fixed latency, selectable lane function) and a matrix-level
// reference model feeding an expected-row queue.
module tb_dct_2d_ctrl;

    localparam int DW = 32;
    localparam int L  = 3;
    localparam int VW = DW * 8;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [VW-1:0] eng_data_in;
    logic [VW-1:0] eng_data_out;
    logic          busy;
    logic          block_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int eng_mode = 0;

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] blk [8];
    logic [VW-1:0] eng_pipe [L];

    dct_2d_ctrl #(.DATA_WIDTH(DW), .ENGINE_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .eng_data_in(eng_data_in), .eng_data_out(eng_data_out),
        .busy(busy), .block_done(block_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine lane function: 0 identity, 1 doubling, 2 lane reversal.
    function automatic logic [VW-1:0] eng_apply(input int mode, input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            case (mode)
                1:       r[k*DW +: DW] = v[k*DW +: DW] * 2;
                2:       r[k*DW +: DW] = v[(7-k)*DW +: DW];
                default: r[k*DW +: DW] = v[k*DW +: DW];
            endcase
        end
        return r;
    endfunction

    // Engine model: pure L-cycle latency, no reset, stale data never cleared.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (block_done) done_cnt <= done_cnt + 1;
        eng_pipe[0] <= eng_apply(eng_mode, eng_data_in);
        for (int i = 1; i < L; i++) eng_pipe[i] <= eng_pipe[i-1];
    end
    assign eng_data_out = eng_pipe[L-1];

    // Reference: T = engine(row r); Y[v][u] = engine(column u of T)[v].
    task automatic push_expected();
        logic [VW-1:0] t [8];
        logic [VW-1:0] y [8];
        logic [VW-1:0] colv;
        logic [VW-1:0] res;
        for (int r = 0; r < 8; r++) t[r] = eng_apply(eng_mode, blk[r]);
        for (int v = 0; v < 8; v++) y[v] = '0;
        for (int u = 0; u < 8; u++) begin
            colv = '0;
            for (int r = 0; r < 8; r++) colv[r*DW +: DW] = t[r][u*DW +: DW];
            res = eng_apply(eng_mode, colv);
            for (int v = 0; v < 8; v++) y[v][u*DW +: DW] = res[v*DW +: DW];
        end
        for (int v = 0; v < 8; v++) exp_q.push_back(y[v]);
    endtask

    task automatic fill_pattern(input int scale);
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) blk[r][j*DW +: DW] = scale * (8*r + j);
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) blk[r][j*DW +: DW] = $urandom;
    endtask

    // driver: send the 8 rows of blk; returns edge numbers of 1st and 8th accept
    task automatic send_block(input bit gaps, output int acc0, output int acc7);
        int  i = 0;
        int  guard = 0;
        bit  skip = 1'b0;
        acc0 = 0;
        acc7 = 0;
        while (i < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (gaps && skip) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = blk[i];
            end
            if (in_valid && in_ready) begin
                if (i == 0) acc0 = cyc + 1;
                if (i == 7) acc7 = cyc + 1;
                i++;
            end
            skip = gaps ? !skip : 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (i != 8) begin
            errors++;
            $display("FAIL send_timeout: accepted %0d rows, required 8", i);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_after_8th: got %b, required 0", in_ready);
        end
    endtask

    // receiver: drain 8 output beats against exp_q, optional stall and latency check
    task automatic recv_block(input int stall_beat, input int stall_len,
                              input int acc0, input bit check_lat);
        int beat = 0;
        int guard = 0;
        int stalled = 0;
        int done0;
        bit first = 1'b1;
        logic exp_done;
        done0 = done_cnt;
        while (beat < 8 && guard < 300) begin
            @(negedge clk);
            guard++;
            out_ready = !(beat == stall_beat && stalled < stall_len);
            #1;
            if (out_valid) begin
                if (first && check_lat) begin
                    checks++;
                    if (cyc - acc0 != 2*8 + 2*L + 1) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, required %0d", cyc - acc0, 2*8 + 2*L + 1);
                    end
                end
                first = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got beat with empty expected queue, required none");
                end else if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL out_data beat %0d: got %h, required %h", beat, out_data, exp_q[0]);
                end
                checks++;
                exp_done = out_ready && (beat == 7);
                if (block_done !== exp_done) begin
                    errors++;
                    $display("FAIL block_done beat %0d: got %b, required %b", beat, block_done, exp_done);
                end
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL out_flags: got in_ready=%b busy=%b, required 0/1", in_ready, busy);
                end
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    beat++;
                end else begin
                    stalled++;
                end
            end else begin
                checks++;
                if (in_ready !== 1'b0 || block_done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_flags: got in_ready=%b block_done=%b busy=%b, required 0/0/1",
                             in_ready, block_done, busy);
                end
            end
        end
        checks++;
        if (beat != 8) begin
            errors++;
            $display("FAIL recv_timeout: got %0d beats, required 8", beat);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_block: got out_valid=%b busy=%b in_ready=%b, required 0/0/1",
                     out_valid, busy, in_ready);
        end
        checks++;
        if (done_cnt != done0 + 1) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, required 1", done_cnt - done0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
            eng_data_in !== '0 || busy !== 1'b0 || block_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got in_ready=%b out_valid=%b out_data=%h eng_data_in=%h busy=%b block_done=%b, required all 0",
                     tag, in_ready, out_valid, out_data, eng_data_in, busy, block_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_released");
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
    endtask

    task automatic test_identity();
        int a0, a7;
        eng_mode = 0;
        fill_pattern(1);
        push_expected();
        send_block(1'b0, a0, a7);
        recv_block(-1, 0, a0, 1'b1);
    endtask

    task automatic test_double();
        int a0, a7;
        eng_mode = 1;
        fill_pattern(1);
        push_expected();
        // Independent spot check of the model: lane u of row v is 4*(8v+u).
        checks++;
        if (exp_q[exp_q.size()-3][5*DW +: DW] !== 32'(4*(8*5+5))) begin
            errors++;
            $display("FAIL model_double: got %0d, required %0d", exp_q[exp_q.size()-3][5*DW +: DW], 4*45);
        end
        send_block(1'b0, a0, a7);
        recv_block(-1, 0, a0, 1'b1);
    endtask

    task automatic test_gaps();
        int a0, a7;
        eng_mode = 0;
        fill_random();
        push_expected();
        send_block(1'b1, a0, a7);
        recv_block(-1, 0, a0, 1'b0);
    endtask

    task automatic test_backpressure();
        int a0, a7;
        eng_mode = 2;
        fill_random();
        push_expected();
        send_block(1'b0, a0, a7);
        recv_block(3, 5, a0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int a0, a7;
        int guard = 0;
        eng_mode = 0;
        fill_random();
        send_block(1'b0, a0, a7);
        // Column 4 is registered onto the engine at edge a0 + 8 + L + 1 + 4.
        while (cyc < a0 + 8 + L + 5 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_col_state: got busy=%b out_valid=%b, required 1/0", busy, out_valid);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_col");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        eng_mode = 1;
        fill_random();
        push_expected();
        send_block(1'b0, a0, a7);
        recv_block(-1, 0, a0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int a0, a7;
        eng_mode = 2;
        fill_random();
        push_expected();
        send_block(1'b0, a0, a7);
        recv_block(-1, 0, a0, 1'b1);
        eng_mode = 0;
        fill_random();
        push_expected();
        send_block(1'b0, a0, a7);
        recv_block(-1, 0, a0, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_identity();
        test_double();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_2d_ctrl.md
Name: dct_2d_ctrl

Overview:
- Sequences one shared dct_1d_8x1 engine to compute a full 8x8 2D DCT: a row pass of 8 row vectors, on-chip transpose, then a column pass of 8 column vectors.
- Sits between the pixel block source and quantisation. Input and output are row-streamed with valid/ready handshakes.
- Coefficient matrix wiring to the engine is outside this block.

Parameters:
- DATA_WIDTH, 32, width of one sample/coefficient word.
- ENGINE_LAT, 3, fixed cycles from engine input applied to matching engine output valid (1..8).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input row beat valid.
- in_ready  out  1  controller accepts input row.
- in_data  in  DATA_WIDTH*8  one input row; lane j at [j*DATA_WIDTH +: DATA_WIDTH] = column j.
- out_valid  out  1  output row beat valid.
- out_ready  in  1  sink accepts output row.
- out_data  out  DATA_WIDTH*8  one output row v; lane u = F(v,u).
- eng_data_in  out  DATA_WIDTH*8  vector driven to engine data_in.
- eng_data_out  in  DATA_WIDTH*8  engine dct_out.
- busy  out  1  high in any state other than IDLE.
- block_done  out  1  one-cycle pulse on acceptance of the 8th output beat.

Behaviour:
- Reset: state=IDLE. Row counter, column counter, capture counter and output counter = 0. Tag pipeline cleared. in_ready=0, out_valid=0, out_data=0, eng_data_in=0, busy=0, block_done=0.
- Buffers tbuf[8][8] and obuf[8][8] are not cleared by reset. Their contents are don't-care until written.
- Engine issue: eng_data_in is registered. A 1-bit tag shift register of depth ENGINE_LAT marks valid issues. Tag out high means capture eng_data_out this cycle. Untagged engine outputs are ignored.
- IDLE: in_ready=1. Go to ROW on in_valid. That first beat is accepted as row 0.
- ROW: in_ready=1 until 8 rows are accepted. Each accepted beat (in_valid&&in_ready) is registered onto eng_data_in with tag=1. Gaps in in_valid issue nothing (tag=0).
- ROW capture: each tagged result for row r is written as tbuf[r][u] = lane u. The capture counter increments per tagged result.
- ROW exit: after the 8th row is captured, go to COL. in_ready drops the cycle after the 8th acceptance.
- COL: one column per cycle, 8 consecutive cycles. Column u drives lane r = tbuf[r][u], tag=1.
- COL capture: the tagged result for column u is written as obuf[v][u] = lane v. After the 8th capture, go to OUT.
- No column is issued before all 8 row results are in tbuf. Minimum row-to-column gap is ENGINE_LAT cycles.
- OUT: out_valid=1 and out_data = obuf[k] for output counter k. k advances on out_valid&&out_ready. out_data is stable while out_ready=0.
- OUT exit: on acceptance of k=7, block_done pulses in the same cycle and the state returns to IDLE. out_valid=0 the next cycle.
- Latency with no backpressure and no input gaps: first out_valid occurs 8+ENGINE_LAT+8+ENGINE_LAT+1 cycles after the first input acceptance.
- Throughput: one block at a time. in_ready=0 in COL and OUT; a new block starts only from IDLE.
- Simultaneous events: in the ROW state, a new acceptance and a capture in the same cycle are both performed. Counters are independent.
- Reset mid-operation: immediate return to IDLE with all counters and tags zero. Engine results still in flight are ignored because their tags are cleared. The next block is processed correctly.
- Arithmetic: none in this block. Data are moved bit-exact and DATA_WIDTH is preserved.

Test Plan:
- Identity engine model (delay ENGINE_LAT, out=in), in_data row r lane j = 8r+j, out_ready=1 -> output beat v lane u = 8v+u. block_done pulses once. First out_valid is 8+3+8+3+1=23 cycles after the first accept.
- Engine model lane v = 2*in lane v, same input -> out lane u of row v = 4*(8v+u). Confirms both passes are applied and the transposes are correct.
- Input gaps (in_valid toggled 1,0,1,0…) -> same outputs as the identity test. No spurious captures; tbuf is written exactly 8 times.
- out_ready held low 5 cycles at beat 3 -> out_data stays at row 3 and out_valid stays 1. No beat is lost or duplicated; block_done is on the 8th accept only.
- Reset asserted during COL (column 4 issued), then a new block sent -> after reset all outputs are 0. The new block's output is correct, with no data from the aborted block.
- Two back-to-back blocks -> in_ready=0 from the cycle after the 8th accept until IDLE. The second block's output is correct.
